// File: rtl/router_pkg.sv
// Shared types and helpers for the router port logic.
package router_pkg;

    typedef enum logic {IDLE, BODY} tx_state_t;

    // Bits needed to hold a credit count from 0 up to depth inclusive.
    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/router_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module router_credit_counter
    import router_pkg::*;
#(
    parameter int unsigned CreditDepth = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                consume,
    input  logic                                release_req,
    output logic [credit_w(CreditDepth)-1:0]    count,
    output logic                                nonzero,
    output logic                                ovf
);

    localparam int unsigned CW = credit_w(CreditDepth);
    localparam logic [CW-1:0] MaxCount = CW'(CreditDepth);

    logic [CW-1:0] count_d, count_q;
    logic          ovf_d, ovf_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (consume && !release_req) begin
            count_d = count_q - CW'(1);
        end else if (release_req && !consume) begin
            if (count_q == MaxCount) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= MaxCount;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign ovf     = ovf_q;

endmodule

// File: rtl/router_credit_tx.sv
// Credit-based flit transmitter: registers accepted flits onto the link and tracks
// downstream FIFO space with credits, enforcing head..tail wormhole framing.
module router_credit_tx
    import router_pkg::*;
#(
    parameter int unsigned Width       = 8,
    parameter int unsigned CreditDepth = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [Width-1:0]                 in_data,
    input  logic                             in_head,
    input  logic                             in_tail,
    output logic                             out_valid,
    output logic [Width-1:0]                 out_data,
    input  logic                             credit_in,
    output logic [credit_w(CreditDepth)-1:0] credits,
    output logic                             busy,
    output logic                             err_credit_ovf,
    output logic                             err_framing
);

    logic             accept;
    logic             credit_nonzero;
    tx_state_t        state_d, state_q;
    logic             err_framing_d, err_framing_q;
    logic             out_valid_d, out_valid_q;
    logic [Width-1:0] out_data_d, out_data_q;

    router_credit_counter #(
        .CreditDepth (CreditDepth)
    ) u_credit_counter (
        .clk         (clk),
        .rst         (rst),
        .consume     (accept),
        .release_req (credit_in),
        .count       (credits),
        .nonzero     (credit_nonzero),
        .ovf         (err_credit_ovf)
    );

    // Ready looks only at the registered count, so a same-cycle credit cannot raise it.
    assign in_ready = credit_nonzero;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            err_framing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_framing_q <= err_framing_d;
        end
    end

    // Malformed flits are still forwarded; a stray body flit in IDLE opens a packet.
    always_comb begin
        state_d       = state_q;
        err_framing_d = err_framing_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!in_head) err_framing_d = 1'b1;
                    if (!in_tail) state_d = BODY;
                end
                BODY: begin
                    if (in_head) err_framing_d = 1'b1;
                    if (in_tail) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q == BODY);
        err_framing = err_framing_q;
    end

    always_comb begin
        out_valid_d = accept;
        out_data_d  = accept ? in_data : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
